// File: rtl/cordic_pkg.sv
// ---------------------------------------------------------------------------
// cordic_pkg
//   Shared constants and types for the CORDIC engine.
//   - MODE_ROT / MODE_VEC : run-time mode encodings
//   - ATAN_TAB            : atan(2^-i) as a binary angle, 2^31 == pi, i = 0..31
//   - INV_GAIN_Q31        : round(2^31 / K), the CORDIC gain reciprocal
//   - round_to_width()    : rounds a 32-bit binary-angle/Q31 constant to a
//                           narrower width (2^(width-1) == full scale)
//   - stage_ctl_t         : control part of a pipeline stage record
// ---------------------------------------------------------------------------
package cordic_pkg;

    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;

    localparam logic [31:0] ATAN_TAB [0:31] = '{
        32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
        32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
        32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
        32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
        32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
        32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
        32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
        32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
    };

    // 1/K = 0.60725293500888 scaled by 2^31
    localparam logic [31:0] INV_GAIN_Q31 = 32'd1304065748;

    typedef struct packed {
        logic valid;
        logic mode;
    } stage_ctl_t;

    // Round-half-up from 32-bit precision down to 'width' bits.
    function automatic logic [31:0] round_to_width(input logic [31:0] v, input int width);
        if (width >= 32)
            return v;
        return (v + (32'd1 << (31 - width))) >> (32 - width);
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// ---------------------------------------------------------------------------
// cordic_stage
//   One registered CORDIC micro-rotation by +/- atan(2^-SHIFT).
//   Parameters: WIDTH (angle width), IW (x/y width), SHIFT (stage index),
//               ATAN (stage angle, binary angle), RST_DATA (also clear x/y/z
//               on reset; used when this stage drives the core outputs).
//   Ports:
//     clk, reset   clock, synchronous active-high reset
//     ce           advance enable; all registers hold when low
//     i_vld/i_mode valid and mode of the incoming sample
//     i_x,i_y,i_z  incoming vector / angle
//     o_vld        registered valid
//     o_x,o_y,o_z  registered rotated vector / updated angle
// ---------------------------------------------------------------------------
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter int               IW       = 18,
    parameter int               SHIFT    = 0,
    parameter logic [WIDTH-1:0] ATAN     = '0,
    parameter bit               RST_DATA = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ce,
    input  logic                    i_vld,
    input  logic                    i_mode,
    input  logic signed [IW-1:0]    i_x,
    input  logic signed [IW-1:0]    i_y,
    input  logic signed [WIDTH-1:0] i_z,
    output logic                    o_vld,
    output logic signed [IW-1:0]    o_x,
    output logic signed [IW-1:0]    o_y,
    output logic signed [WIDTH-1:0] o_z
);

    logic                    w_d;
    logic signed [IW-1:0]    w_xs;
    logic signed [IW-1:0]    w_ys;
    logic                    r_vld_p;
    logic signed [IW-1:0]    r_x_p;
    logic signed [IW-1:0]    r_y_p;
    logic signed [WIDTH-1:0] r_z_p;

    assign w_xs = i_x >>> SHIFT;
    assign w_ys = i_y >>> SHIFT;

    // d=1 rotates counter-clockwise: rotation mode drives z toward 0,
    // vectoring mode drives y toward 0.
    assign w_d = (i_mode == MODE_ROT) ? ~i_z[WIDTH-1] : i_y[IW-1];

    // stage register
    always_ff @(posedge clk) begin
        if (ce) begin
            r_x_p <= w_d ? (i_x - w_ys) : (i_x + w_ys);
            r_y_p <= w_d ? (i_y + w_xs) : (i_y - w_xs);
            r_z_p <= w_d ? (i_z - ATAN) : (i_z + ATAN);
        end
        if (reset && RST_DATA) begin
            r_x_p <= '0;
            r_y_p <= '0;
            r_z_p <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_vld_p <= 1'b0;
        else if (ce)
            r_vld_p <= i_vld;
    end

    assign o_vld = r_vld_p;
    assign o_x   = r_x_p;
    assign o_y   = r_y_p;
    assign o_z   = r_z_p;

endmodule

// File: rtl/cordic_engine.sv
// ---------------------------------------------------------------------------
// cordic_engine
//   Fully pipelined CORDIC core, run-time rotation/vectoring select, full
//   +/-pi range via a quadrant pre-rotation stage, valid/ready backpressure.
//   Optional macro CORDIC_GAIN_COMP_EN: adds one register stage that scales
//   x/y by 1/K (unity gain output); latency becomes STAGES+2.
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     in_valid / in_ready   input handshake (in_ready = pipeline advance)
//     mode                  0 rotation (z->0), 1 vectoring (y->0)
//     x_in, y_in, z_in      signed inputs, z in binary angle (2^(WIDTH-1)=pi)
//     out_valid / out_ready output handshake
//     x_out, y_out          WIDTH+GUARD signed results
//     z_out                 residual / accumulated angle
// ---------------------------------------------------------------------------
module cordic_engine
    import cordic_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 16,
    parameter int GUARD  = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          mode,
    input  logic signed [WIDTH-1:0]       x_in,
    input  logic signed [WIDTH-1:0]       y_in,
    input  logic signed [WIDTH-1:0]       z_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [WIDTH+GUARD-1:0] x_out,
    output logic signed [WIDTH+GUARD-1:0] y_out,
    output logic signed [WIDTH-1:0]       z_out
);

    localparam int IW = WIDTH + GUARD;
    localparam logic signed [WIDTH-1:0] HALF_PI = signed'({2'b01, {(WIDTH-2){1'b0}}});
    localparam logic [WIDTH-1:0]        PI_BA   = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef CORDIC_GAIN_COMP_EN
    localparam bit LAST_RST = 1'b0;
    localparam logic [31:0]             INV_K_32 = round_to_width(INV_GAIN_Q31, WIDTH);
    localparam logic signed [WIDTH:0]   INV_K    = signed'({1'b0, INV_K_32[WIDTH-1:0]});

    // x * round(2^(WIDTH-1)/K) >>> (WIDTH-1); result fits IW once gain is removed.
    function automatic logic signed [IW-1:0] scale_gain(input logic signed [IW-1:0] v);
        return IW'(((IW+WIDTH+1)'(v) * (IW+WIDTH+1)'(INV_K)) >>> (WIDTH-1));
    endfunction
`else
    localparam bit LAST_RST = 1'b1;
`endif

    logic                    w_ce;
    logic                    w_flip;
    logic signed [IW-1:0]    w_x_ext;
    logic signed [IW-1:0]    w_y_ext;

    stage_ctl_t              r_ctl_p0;
    logic signed [IW-1:0]    r_x_p0;
    logic signed [IW-1:0]    r_y_p0;
    logic signed [WIDTH-1:0] r_z_p0;

    logic                    w_vld  [0:STAGES];
    logic                    w_mode [0:STAGES-1];
    logic signed [IW-1:0]    w_x    [0:STAGES];
    logic signed [IW-1:0]    w_y    [0:STAGES];
    logic signed [WIDTH-1:0] w_z    [0:STAGES];

    // Whole pipe advances together; a held output stalls everything.
    assign w_ce     = ~out_valid | out_ready;
    assign in_ready = w_ce;

    assign w_x_ext = IW'(x_in);
    assign w_y_ext = IW'(y_in);

    // Pre-rotate by pi into the right half-plane (|angle| <= pi/2) so the
    // micro-rotations, which only cover ~+/-99.9 deg, can converge.
    assign w_flip = (mode == MODE_ROT) ? ((z_in > HALF_PI) || (z_in < -HALF_PI))
                                       : x_in[WIDTH-1];

    // stage P: pre-rotation register
    always_ff @(posedge clk) begin
        if (w_ce) begin
            r_ctl_p0.mode <= mode;
            r_x_p0        <= w_flip ? -w_x_ext : w_x_ext;
            r_y_p0        <= w_flip ? -w_y_ext : w_y_ext;
            r_z_p0        <= w_flip ? (z_in + PI_BA) : z_in;
        end
        if (reset)
            r_ctl_p0.valid <= 1'b0;
        else if (w_ce)
            r_ctl_p0.valid <= in_valid;
    end

    assign w_vld[0]  = r_ctl_p0.valid;
    assign w_mode[0] = r_ctl_p0.mode;
    assign w_x[0]    = r_x_p0;
    assign w_y[0]    = r_y_p0;
    assign w_z[0]    = r_z_p0;

    // mode rides alongside its sample, one register per stage
    for (genvar i = 1; i < STAGES; i++) begin : g_mode
        logic r_mode_p;
        always_ff @(posedge clk) begin
            if (w_ce)
                r_mode_p <= w_mode[i-1];
        end
        assign w_mode[i] = r_mode_p;
    end

    // stages 0..STAGES-1: micro-rotations
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        localparam logic [31:0] ATAN_R = round_to_width(ATAN_TAB[i], WIDTH);
        cordic_stage #(
            .WIDTH    (WIDTH),
            .IW       (IW),
            .SHIFT    (i),
            .ATAN     (ATAN_R[WIDTH-1:0]),
            .RST_DATA ((i == STAGES-1) && LAST_RST)
        ) u_stage (
            .clk    (clk),
            .reset  (reset),
            .ce     (w_ce),
            .i_vld  (w_vld[i]),
            .i_mode (w_mode[i]),
            .i_x    (w_x[i]),
            .i_y    (w_y[i]),
            .i_z    (w_z[i]),
            .o_vld  (w_vld[i+1]),
            .o_x    (w_x[i+1]),
            .o_y    (w_y[i+1]),
            .o_z    (w_z[i+1])
        );
    end

`ifdef CORDIC_GAIN_COMP_EN
    logic                    r_vld_pg;
    logic signed [IW-1:0]    r_x_pg;
    logic signed [IW-1:0]    r_y_pg;
    logic signed [WIDTH-1:0] r_z_pg;

    // stage G: gain compensation
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_pg <= 1'b0;
            r_x_pg   <= '0;
            r_y_pg   <= '0;
            r_z_pg   <= '0;
        end else if (w_ce) begin
            r_vld_pg <= w_vld[STAGES];
            r_x_pg   <= scale_gain(w_x[STAGES]);
            r_y_pg   <= scale_gain(w_y[STAGES]);
            r_z_pg   <= w_z[STAGES];
        end
    end

    assign out_valid = r_vld_pg;
    assign x_out     = r_x_pg;
    assign y_out     = r_y_pg;
    assign z_out     = r_z_pg;
`else
    assign out_valid = w_vld[STAGES];
    assign x_out     = w_x[STAGES];
    assign y_out     = w_y[STAGES];
    assign z_out     = w_z[STAGES];
`endif

endmodule
